placar_partida: RTL and testbench
=================================

// Module: placar_partida
// PURPOSE
//  Parametrised match scoreboard for the two-player game; successor of the 8-point LED score block.
//  Counts round wins per player from the game FSM and lights an LED bar from both ends.
//  Detects end of match, a winner or a draw. Holds the result until a new match is requested.
//  Sits between the game-control FSM (p1vic/p2vic) and the board LEDs.
// PARAMETERS
//  LED_W      16          LED bar width; must be even.
//  MAX_PTS    8           points needed to win; elaboration error if MAX_PTS > LED_W/2.
//  BLINK_DIV  25_000_000  clock cycles per blink half-period (PLACAR_PISCA_EN only); >= 1.
// PORTS
//  clock      in   1            system clock, rising edge
//  reset      in   1            asynchronous, active-high reset
//  p1vic      in   1            player 1 round win; level or pulse; one point per rising edge
//  p2vic      in   1            player 2 round win; same rules as p1vic
//  novo_jogo  in   1            synchronous clear: starts a new match
//  LED        out  LED_W        score bar: p1 fills from bit 0 upward, p2 from bit LED_W-1 downward
//  p1pontos   out  PW           p1 score, PW = $clog2(MAX_PTS+1)
//  p2pontos   out  PW           p2 score
//  fim        out  1            match over
//  vencedor   out  2            00 none, 01 p1, 10 p2, 11 draw
// BEHAVIOUR
//  Reset (async) values: LED=0, p1pontos=p2pontos=0, fim=0, vencedor=00, state JOGANDO,
//    edge registers=0, blink counter=0.
//  Edge detect: evN = pNvic & ~pNvic_q; pNvic_q is registered every cycle in all states.
//    A held level scores once. A 1-cycle pulse scores once.
//  Latency: edge sampled at clock k -> score and LED updated at clock k (visible after k).
//  LED is registered. Invariant: LED[i]=1 iff i<p1pontos; LED[LED_W-1-i]=1 iff i<p2pontos.
//    The halves never overlap.
//  FSM JOGANDO:
//    - evN with pNpontos<MAX_PTS -> pNpontos+1.
//    - Both edges in the same cycle -> both scores increment in that cycle.
//    - Any score reaching MAX_PTS in that update -> FIM in the same update: fim=1, vencedor=01/10.
//    - Both reaching MAX_PTS in the same cycle -> vencedor=11.
//  FSM FIM:
//    - p1vic/p2vic edges are ignored; scores and vencedor are held.
//  novo_jogo (either state):
//    - Next clock: scores=0, LED=0, fim=0, vencedor=00, state JOGANDO.
//    - Wins over any edge in the same cycle; that edge is discarded.
//  Counters saturate at MAX_PTS and never wrap.
//  Reset mid-match clears everything at once, regardless of state.
// CONFIGURATION
//  PLACAR_PISCA_EN defined:
//    - In FIM, the winner's LED half toggles between its score pattern and 0 every BLINK_DIV cycles.
//    - A draw blinks both halves. The phase starts "on" when FIM is entered.
//    - The blink counter is cleared by reset and by novo_jogo.
//  PLACAR_PISCA_EN undefined:
//    - LED stays static in FIM. No blink counter is synthesised. BLINK_DIV is unused.
// STRUCTURE
//  Package placar_pkg:
//    - typedef enum logic {JOGANDO, FIM} estado_t
//    - localparams VENC_NENHUM=2'b00, VENC_P1=2'b01, VENC_P2=2'b10, VENC_EMPATE=2'b11
//  Sub-module detector_borda (clock, reset, din, pulso): rising-edge detector, instanced for p1 and p2.
//  Top holds the FSM, the two score counters, the LED register and the optional blink divider.
// TESTING
//  1. Assert reset mid-activity -> same cycle: LED=0, scores 0, fim=0, vencedor=00.
//  2. p1vic held high 5 cycles -> p1pontos=1, LED=16'h0001; release and one more pulse -> 2, 16'h0003.
//  3. Three p2vic pulses -> p2pontos=3, LED=16'hE000; p1pontos stays 0.
//  4. p1vic and p2vic rise in the same cycle, 8 times -> both reach 8 together; LED=16'hFFFF, fim=1, vencedor=11.
//  5. p1 to 8 while p2=2 -> LED=16'hC0FF, fim=1, vencedor=01; later p2vic pulses ignored;
//     novo_jogo -> all cleared; novo_jogo with a p1vic edge in the same cycle -> p1pontos=0.
//  6. PLACAR_PISCA_EN, BLINK_DIV=4, p1 wins -> low byte alternates 8'hFF/8'h00 every 4 cycles;
//     p2 half stays static.

Source files
------------

// File: rtl/placar_pkg.sv
// Shared types and result codes for the match scoreboard (placar_partida).
package placar_pkg;

  typedef enum logic {JOGANDO, FIM} estado_t;

  localparam logic [1:0] VENC_NENHUM = 2'b00;
  localparam logic [1:0] VENC_P1     = 2'b01;
  localparam logic [1:0] VENC_P2     = 2'b10;
  localparam logic [1:0] VENC_EMPATE = 2'b11;

endpackage

// File: rtl/placar_partida_detector_borda.sv
// Rising-edge detector: one-cycle pulso on each 0->1 transition of din.
module detector_borda (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic pulso
);

  logic r_din_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_din_q <= 1'b0;
    else       r_din_q <= din;
  end

  assign pulso = din & ~r_din_q;

endmodule

// File: rtl/placar_partida.sv
// Match scoreboard: counts round wins, drives a two-ended LED bar, flags winner/draw.
// Optional LED blinking of the winner's half in FIM when PLACAR_PISCA_EN is defined.
module placar_partida
  import placar_pkg::*;
#(
  parameter  int LED_W     = 16,
  parameter  int MAX_PTS   = 8,
  parameter  int BLINK_DIV = 25_000_000,
  localparam int PW        = $clog2(MAX_PTS + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             p1vic,
  input  logic             p2vic,
  input  logic             novo_jogo,
  output logic [LED_W-1:0] LED,
  output logic [PW-1:0]    p1pontos,
  output logic [PW-1:0]    p2pontos,
  output logic             fim,
  output logic [1:0]       vencedor
);

  localparam logic [PW-1:0] MAXP = PW'(MAX_PTS);
  localparam int HALF = LED_W / 2;

  if (LED_W % 2 != 0) begin : g_chk_even
    $error("placar_partida: LED_W must be even");
  end
  if (MAX_PTS > HALF) begin : g_chk_max
    $error("placar_partida: MAX_PTS must not exceed LED_W/2");
  end
  if (BLINK_DIV < 1) begin : g_chk_div
    $error("placar_partida: BLINK_DIV must be >= 1");
  end

  logic w_ev1, w_ev2;

  detector_borda u_borda_p1 (.clock(clock), .reset(reset), .din(p1vic), .pulso(w_ev1));
  detector_borda u_borda_p2 (.clock(clock), .reset(reset), .din(p2vic), .pulso(w_ev2));

  estado_t          r_st,   w_st_n;
  logic [PW-1:0]    r_p1,   w_p1_n;
  logic [PW-1:0]    r_p2,   w_p2_n;
  logic             r_fim,  w_fim_n;
  logic [1:0]       r_venc, w_venc_n;
  logic [LED_W-1:0] r_led,  w_led_n;

`ifdef PLACAR_PISCA_EN
  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(BLINK_DIV - 1);
  logic          r_fase, w_fase_n;
  logic [CW-1:0] r_cnt,  w_cnt_n;
`endif

  always_comb begin
    w_st_n   = r_st;
    w_p1_n   = r_p1;
    w_p2_n   = r_p2;
    w_fim_n  = r_fim;
    w_venc_n = r_venc;
`ifdef PLACAR_PISCA_EN
    w_fase_n = r_fase;
    w_cnt_n  = r_cnt;
`endif
    // novo_jogo takes priority; any edge in the same cycle is discarded
    if (novo_jogo) begin
      w_st_n   = JOGANDO;
      w_p1_n   = '0;
      w_p2_n   = '0;
      w_fim_n  = 1'b0;
      w_venc_n = VENC_NENHUM;
`ifdef PLACAR_PISCA_EN
      w_fase_n = 1'b1;
      w_cnt_n  = '0;
`endif
    end else if (r_st == JOGANDO) begin
      if (w_ev1 && r_p1 < MAXP) w_p1_n = r_p1 + PW'(1);
      if (w_ev2 && r_p2 < MAXP) w_p2_n = r_p2 + PW'(1);
      if (w_p1_n == MAXP || w_p2_n == MAXP) begin
        w_st_n   = FIM;
        w_fim_n  = 1'b1;
        w_venc_n = {w_p2_n == MAXP, w_p1_n == MAXP};
`ifdef PLACAR_PISCA_EN
        w_fase_n = 1'b1;
        w_cnt_n  = '0;
`endif
      end
    end else begin
`ifdef PLACAR_PISCA_EN
      if (r_cnt == CNT_TOP) begin
        w_cnt_n  = '0;
        w_fase_n = ~r_fase;
      end else begin
        w_cnt_n  = r_cnt + CW'(1);
      end
`endif
    end

    // LED image is derived from the next scores so it updates with them
    w_led_n = '0;
    for (int i = 0; i < HALF; i++) begin
      if (i < int'(w_p1_n)) w_led_n[i]           = 1'b1;
      if (i < int'(w_p2_n)) w_led_n[LED_W-1-i]   = 1'b1;
    end
`ifdef PLACAR_PISCA_EN
    if (w_st_n == FIM && !w_fase_n) begin
      if (w_venc_n[0]) w_led_n[HALF-1:0]     = '0;
      if (w_venc_n[1]) w_led_n[LED_W-1:HALF] = '0;
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_st   <= JOGANDO;
      r_p1   <= '0;
      r_p2   <= '0;
      r_fim  <= 1'b0;
      r_venc <= VENC_NENHUM;
      r_led  <= '0;
`ifdef PLACAR_PISCA_EN
      r_fase <= 1'b1;
      r_cnt  <= '0;
`endif
    end else begin
      r_st   <= w_st_n;
      r_p1   <= w_p1_n;
      r_p2   <= w_p2_n;
      r_fim  <= w_fim_n;
      r_venc <= w_venc_n;
      r_led  <= w_led_n;
`ifdef PLACAR_PISCA_EN
      r_fase <= w_fase_n;
      r_cnt  <= w_cnt_n;
`endif
    end
  end

  assign LED      = r_led;
  assign p1pontos = r_p1;
  assign p2pontos = r_p2;
  assign fim      = r_fim;
  assign vencedor = r_venc;

endmodule

// File: tb/tb_placar_partida.sv
// Scoreboard bench for placar_partida: stimulus pushes model results, a monitor pops and compares.
module tb_placar_partida;

  localparam int LED_W = 16;
  localparam int MAXP  = 8;
  localparam int BDIV  = 4;
  localparam int PW    = $clog2(MAXP + 1);

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             p1vic = 1'b0, p2vic = 1'b0, novo_jogo = 1'b0;
  logic [LED_W-1:0] LED;
  logic [PW-1:0]    p1pontos, p2pontos;
  logic             fim;
  logic [1:0]       vencedor;

  placar_partida #(.LED_W(LED_W), .MAX_PTS(MAXP), .BLINK_DIV(BDIV)) dut (
    .clock(clock), .reset(reset), .p1vic(p1vic), .p2vic(p2vic), .novo_jogo(novo_jogo),
    .LED(LED), .p1pontos(p1pontos), .p2pontos(p2pontos), .fim(fim), .vencedor(vencedor)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [LED_W-1:0] led;
    int               s1, s2;
    logic             fim;
    logic [1:0]       venc;
    int               id;
  } exp_t;

  exp_t q[$];
  int n_tests = 0, n_fail = 0, n_cyc = 0;

  // behavioural match model
  int   m_s1, m_s2, m_t;
  bit   m_over, m_pa, m_pb;
  logic [1:0] m_win;

  function automatic logic [LED_W-1:0] exp_led();
    logic [LED_W-1:0] lo, hi;
    lo = (16'd1 << m_s1) - 16'd1;
    hi = ~(16'hFFFF >> m_s2);
`ifdef PLACAR_PISCA_EN
    if (m_over && ((m_t / BDIV) % 2 == 1)) begin
      if (m_win[0]) lo = '0;
      if (m_win[1]) hi = '0;
    end
`endif
    return lo | hi;
  endfunction

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_t = 0; m_over = 0; m_pa = 0; m_pb = 0; m_win = 2'b00;
  endtask

  task automatic cyc(input bit a, input bit b, input bit n);
    exp_t e;
    bit ea, eb;
    @(negedge clock);
    p1vic = a; p2vic = b; novo_jogo = n;
    ea = a && !m_pa; eb = b && !m_pb;
    m_pa = a; m_pb = b;
    if (n) begin
      m_s1 = 0; m_s2 = 0; m_over = 0; m_win = 2'b00; m_t = 0;
    end else if (!m_over) begin
      if (ea && m_s1 < MAXP) m_s1++;
      if (eb && m_s2 < MAXP) m_s2++;
      if (m_s1 == MAXP || m_s2 == MAXP) begin
        m_over = 1; m_t = 0;
        m_win = {m_s2 == MAXP, m_s1 == MAXP};
      end
    end else begin
      m_t++;
    end
    e.led = exp_led(); e.s1 = m_s1; e.s2 = m_s2; e.fim = m_over; e.venc = m_win;
    e.id = n_cyc++;
    q.push_back(e);
  endtask

  task automatic pulses(input int k, input bit a, input bit b);
    for (int i = 0; i < k; i++) begin
      cyc(a, b, 0);
      cyc(0, 0, 0);
    end
  endtask

  task automatic reset_check();
    int guard = 0;
    while (q.size() != 0 && guard < 50) begin @(posedge clock); guard++; end
    @(posedge clock); #3;
    reset = 1'b1;
    #1;
    n_tests++;
    if (LED !== '0 || p1pontos !== '0 || p2pontos !== '0 || fim !== 1'b0 || vencedor !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_async: LED=%h p1=%0d p2=%0d fim=%b venc=%b, want all zero",
               LED, p1pontos, p2pontos, fim, vencedor);
    end
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  // monitor: DUT presents a fresh result every clock while stimulus is active
  initial begin
    forever begin
      @(posedge clock); #1;
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        n_tests++;
        if (LED !== e.led || int'(p1pontos) != e.s1 || int'(p2pontos) != e.s2 ||
            fim !== e.fim || vencedor !== e.venc) begin
          n_fail++;
          $display("FAIL cyc%0d: got LED=%h p1=%0d p2=%0d fim=%b venc=%b want LED=%h p1=%0d p2=%0d fim=%b venc=%b",
                   e.id, LED, p1pontos, p2pontos, fim, vencedor, e.led, e.s1, e.s2, e.fim, e.venc);
        end
      end
    end
  end

  initial begin
    bit a, b;
    model_reset();
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // activity then reset mid-match
    pulses(3, 1, 0);
    pulses(2, 0, 1);
    reset_check();

    // held level scores once, then another pulse
    for (int i = 0; i < 5; i++) cyc(1, 0, 0);
    cyc(0, 0, 0);
    pulses(1, 1, 0);
    cyc(0, 0, 1);

    // three p2 pulses
    pulses(3, 0, 1);
    cyc(0, 0, 1);

    // simultaneous edges to a draw, then ignored edges in FIM
    pulses(8, 1, 1);
    pulses(2, 1, 1);
    cyc(0, 0, 1);

    // p1 wins 8-2, p2 ignored after, clear, novo_jogo racing an edge
    pulses(2, 0, 1);
    pulses(8, 1, 0);
    for (int i = 0; i < 12; i++) cyc(i % 2, 0, 0);
    pulses(3, 0, 1);
    cyc(0, 0, 1);
    cyc(1, 0, 1);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    pulses(1, 0, 1);

    // randomized play with occasional new-match requests
    a = 0; b = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) a = ~a;
      if ($urandom_range(0, 2) == 0) b = ~b;
      cyc(a, b, $urandom_range(0, 149) == 0);
      if (i == 1500) reset_check();
    end
    cyc(0, 0, 0);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clock);
    @(posedge clock); #2;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
